alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// - Shares the single 8-bit combinational alu between two requesters (req0, req1) with round-robin arbitration.
// - Accepts one operation (cmd, A, B) per grant and drives the alu from registered operands.
// - Captures the result into a response register, derives zero/parity flags itself and returns the result with the requester id.
// - Sits between the control/sequencing logic and the alu instance; the alu itself is instantiated outside this block.
// PARAMETERS
// - DW    8  datapath width; matches the alu inA/inB/rslt width.
// - CMDW  3  alu command width; matches alu_cmd.
// PORTS
// - clk         in   1     single clock; all state updates on posedge clk.
// - rst_n       in   1     reset; synchronous, active-low.
// - req0_valid  in   1     requester 0 has an operation pending.
// - req0_cmd    in   CMDW  requester 0 alu command.
// - req0_a      in   DW    requester 0 operand A.
// - req0_b      in   DW    requester 0 operand B.
// - req0_ready  out  1     requester 0 operation accepted this cycle; combinational.
// - req1_*      same set as req0 (valid, cmd, a, b, ready) for requester 1.
// - alu_cmd     out  CMDW  registered command driven to the alu.
// - alu_a       out  DW    registered operand A driven to the alu.
// - alu_b       out  DW    registered operand B driven to the alu.
// - alu_sc_i    out  1     alu shift-carry in; tied 0.
// - alu_rslt    in   DW    alu result; alu sc_o/zero/pari outputs are NOT used.
// - rsp_valid   out  1     response register holds a result.
// - rsp_ready   in   1     consumer accepts the response.
// - rsp_data    out  DW    captured alu result.
// - rsp_id      out  1     requester that issued the operation (0 or 1).
// - rsp_zero    out  1     1 when rsp_data == 0.
// - rsp_pari    out  1     XOR reduction of rsp_data.
// - busy        out  1     1 in any state other than IDLE.
// - op_cnt      out  8     count of completed responses; wraps 255 -> 0.
// BEHAVIOUR
// - Reset (rst_n = 0 at posedge):
//   - state = IDLE; last_grant = 1, so req0 wins the first tie.
//   - alu_cmd, alu_a, alu_b, rsp_data, rsp_id, rsp_zero, rsp_pari, rsp_valid and op_cnt are all 0.
// - Reset mid-operation discards the in-flight op; no response is ever produced for it.
// - FSM states: IDLE -> EXEC -> RESP -> IDLE.
// - IDLE:
//   - Grant when any reqN_valid is high.
//   - When both are valid, grant the requester != last_grant.
//   - Assert reqN_ready for the winner only, in that same cycle.
//   - At the clock edge, latch the winner's cmd/a/b into alu_cmd/alu_a/alu_b, update last_grant and id, and go to EXEC.
// - EXEC: the alu settles combinationally. At the clock edge:
//   - rsp_data <= alu_rslt; rsp_zero <= (alu_rslt == 0); rsp_pari <= ^alu_rslt; rsp_id <= id.
//   - Go to RESP.
// - RESP:
//   - rsp_valid = 1; rsp_* are held stable until rsp_ready.
//   - On rsp_valid & rsp_ready: op_cnt++, rsp_valid cleared, go to IDLE.
// - reqN_ready is 0 outside IDLE. Requesters hold valid and payload stable until they see ready.
// - Latency: accept in cycle t, rsp_valid high in cycle t+2. Peak throughput is 1 op per 3 cycles.
// - alu_cmd/a/b are held from the grant until the next grant; they are not cleared on return to IDLE.
// - No command is special-cased; 3'b111 yields whatever the alu returns (currently 0, so rsp_zero = 1).
// - All arithmetic is DW-bit; the block does no overflow or carry handling.
// TESTING
// - Reset: hold rst_n = 0 for 2 cycles -> all outputs 0, busy = 0, both ready = 0.
// - req0 add 05 + 03 -> req0_ready in cycle t; at t+2: rsp_valid = 1, data = 08, id = 0, zero = 0, pari = 1.
// - req0 sub 10 - 10 and req1 xor AA ^ 0F both valid right after reset:
//   - req0 is granted first -> data = 00, zero = 1, id = 0.
//   - Then req1 -> data = A5, pari = 0, id = 1.
// - Hold rsp_ready = 0 for 5 cycles in RESP:
//   - rsp_valid and rsp_data are held; reqN_ready = 0; op_cnt is unchanged.
//   - On release, op_cnt increments by 1.
// - Shift right 81 >> 01: pull rst_n low in EXEC -> next cycle state IDLE, rsp_valid = 0, no response is produced.
// - 256 back-to-back ops alternating requesters with both always valid:
//   - Grants strictly alternate.
//   - op_cnt ends at 00.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake and bus bundle between the requesters, the shared alu and the
// response consumer. The slave modport is the arbiter's view.
interface alu_arbiter_if #(
    parameter int DW   = 8,
    parameter int CMDW = 3
);
    // requester 0
    logic            req0_valid;
    logic [CMDW-1:0] req0_cmd;
    logic [DW-1:0]   req0_a;
    logic [DW-1:0]   req0_b;
    logic            req0_ready;
    // requester 1
    logic            req1_valid;
    logic [CMDW-1:0] req1_cmd;
    logic [DW-1:0]   req1_a;
    logic [DW-1:0]   req1_b;
    logic            req1_ready;
    // alu side
    logic [CMDW-1:0] alu_cmd;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic            alu_sc_i;
    logic [DW-1:0]   alu_rslt;
    // response side
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_id;
    logic            rsp_zero;
    logic            rsp_pari;
    // status
    logic            busy;
    logic [7:0]      op_cnt;

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_cmd, req1_a, req1_b,
        output req1_ready,
        output alu_cmd, alu_a, alu_b, alu_sc_i,
        input  alu_rslt,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data, rsp_id, rsp_zero, rsp_pari,
        output busy, op_cnt
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_cmd, req1_a, req1_b,
        input  req1_ready,
        input  alu_cmd, alu_a, alu_b, alu_sc_i,
        output alu_rslt,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data, rsp_id, rsp_zero, rsp_pari,
        input  busy, op_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin front end for a single shared combinational alu.
// One op per grant: IDLE (accept) -> EXEC (alu settles) -> RESP (hold result).
module alu_arbiter #(
    parameter int DW   = 8,
    parameter int CMDW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            last_grant_q;
    logic            id_q;
    logic [CMDW-1:0] alu_cmd_q;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_data_q;
    logic            rsp_id_q;
    logic            rsp_zero_q;
    logic            rsp_pari_q;
    logic [7:0]      op_cnt_q;

    logic            in_idle;
    logic            any_valid;
    logic            grant1_d;

    // Requester 1 wins when it is alone, or on a tie when requester 0 went last.
    assign in_idle   = (state_q == IDLE);
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant1_d  = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);

    assign bus.req0_ready = in_idle & bus.req0_valid & ~grant1_d;
    assign bus.req1_ready = in_idle & grant1_d;

    assign bus.alu_cmd  = alu_cmd_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_sc_i = 1'b0;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_pari  = rsp_pari_q;
    assign bus.busy      = ~in_idle;
    assign bus.op_cnt    = op_cnt_q;

    // Control FSM: grant, capture the alu result, hold it until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_cmd_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_pari_q   <= 1'b0;
            op_cnt_q     <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        // Operands stay on the alu until the next grant.
                        alu_cmd_q    <= grant1_d ? bus.req1_cmd : bus.req0_cmd;
                        alu_a_q      <= grant1_d ? bus.req1_a   : bus.req0_a;
                        alu_b_q      <= grant1_d ? bus.req1_b   : bus.req0_b;
                        last_grant_q <= grant1_d;
                        id_q         <= grant1_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= bus.alu_rslt;
                    rsp_zero_q  <= (bus.alu_rslt == '0);
                    rsp_pari_q  <= ^bus.alu_rslt;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt_q    <= op_cnt_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external alu and checks arbitration,
// latency, back-pressure, mid-op reset and counter wrap.
module tb_alu_arbiter;
    localparam int DW   = 8;
    localparam int CMDW = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt;
    bit         last_win;

    alu_arbiter_if #(.DW(DW), .CMDW(CMDW)) bus ();

    alu_arbiter #(.DW(DW), .CMDW(CMDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural alu: add, sub, and, or, xor, shl, shr, 111 -> 0.
    function automatic logic [7:0] alu_model(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[2:0];
            3'd6:    return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.alu_rslt = alu_model(bus.alu_cmd, bus.alu_a, bus.alu_b);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_cmd = c; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_cmd = c; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        bus.rsp_ready = 1'b0;
        cyc();
        cyc();
        rst_n    = 1'b1;
        exp_cnt  = 8'd0;
        last_win = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        bus.rsp_ready = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if ({bus.alu_cmd, bus.alu_a, bus.alu_b} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_alu: cmd/a/b=%h/%h/%h required 0/00/00", bus.alu_cmd, bus.alu_a, bus.alu_b);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_pari} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b data=%h id=%b zero=%b pari=%b required all 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_pari);
        end
        n_checks++;
        if ({bus.busy, bus.op_cnt, bus.req0_ready, bus.req1_ready, bus.alu_sc_i} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b op_cnt=%h ready=%b%b sc_i=%b required all 0",
                     bus.busy, bus.op_cnt, bus.req0_ready, bus.req1_ready, bus.alu_sc_i);
        end
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        last_win = 1'b1;
        $display("reset: outputs sampled after 2 reset cycles");
    endtask

    task automatic test_add();
        apply_reset();
        set_req(0, 1'b1, 3'd0, 8'h05, 8'h03);
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ready: ready0=%b ready1=%b required 1/0", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        last_win = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || {bus.alu_cmd, bus.alu_a, bus.alu_b} !== {3'd0, 8'h05, 8'h03} || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_exec: busy=%b cmd/a/b=%h/%h/%h rsp_valid=%b required 1 0/05/03 0",
                     bus.busy, bus.alu_cmd, bus.alu_a, bus.alu_b, bus.rsp_valid);
        end
        cyc();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_pari} !== {1'b1, 8'h08, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_rsp: valid=%b data=%h id=%b zero=%b pari=%b required 1 08 0 0 1",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_pari);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (bus.op_cnt !== exp_cnt || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: op_cnt=%h rsp_valid=%b busy=%b required %h 0 0", bus.op_cnt, bus.rsp_valid, bus.busy, exp_cnt);
        end
        $display("add: req0 05+03 -> %h id=%0d", bus.rsp_data, bus.rsp_id);
    endtask

    task automatic test_tie();
        apply_reset();
        set_req(0, 1'b1, 3'd1, 8'h10, 8'h10);
        set_req(1, 1'b1, 3'd4, 8'hAA, 8'h0F);
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first: ready0=%b ready1=%b required 1/0", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        n_checks++;
        if (bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_exec_ready: ready1=%b required 0", bus.req1_ready);
        end
        cyc();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL tie_rsp0: valid=%b data=%h zero=%b id=%b required 1 00 1 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
        end
        $display("tie: req0 10-10 -> %h id=%0d", bus.rsp_data, bus.rsp_id);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second: ready0=%b ready1=%b required 0/1", bus.req0_ready, bus.req1_ready);
        end
        cyc();
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        cyc();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_pari, bus.rsp_zero, bus.rsp_id} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL tie_rsp1: valid=%b data=%h pari=%b zero=%b id=%b required 1 a5 0 0 1",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_pari, bus.rsp_zero, bus.rsp_id);
        end
        $display("tie: req1 AA^0F -> %h id=%0d", bus.rsp_data, bus.rsp_id);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        last_win = 1'b1;
    endtask

    task automatic test_backpressure();
        set_req(0, 1'b1, 3'd2, 8'h3C, 8'h0F);
        #1;
        cyc();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        last_win = 1'b0;
        cyc();
        set_req(1, 1'b1, 3'd3, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h0C || bus.req1_ready !== 1'b0 || bus.op_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL hold_%0d: valid=%b data=%h ready1=%b op_cnt=%h required 1 0c 0 %h",
                         i, bus.rsp_valid, bus.rsp_data, bus.req1_ready, bus.op_cnt, exp_cnt);
            end
            cyc();
        end
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        exp_cnt++;
        n_checks++;
        if (bus.op_cnt !== exp_cnt || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: op_cnt=%h valid=%b required %h 0", bus.op_cnt, bus.rsp_valid, exp_cnt);
        end
        $display("backpressure: 3C&0F held 5 cycles, op_cnt=%h", bus.op_cnt);
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 3'd6, 8'h81, 8'h01);
        #1;
        cyc();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        last_win = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.op_cnt !== 8'd0 || bus.rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset: busy=%b valid=%b op_cnt=%h data=%h required 0 0 00 00",
                     bus.busy, bus.rsp_valid, bus.op_cnt, bus.rsp_data);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet_%0d: valid=%b busy=%b required 0 0", i, bus.rsp_valid, bus.busy);
            end
        end
        $display("reset_mid: 81>>01 discarded, no response");
    endtask

    task automatic test_back_to_back();
        logic [2:0] pc[2];
        logic [7:0] pa[2];
        logic [7:0] pb[2];
        logic [7:0] exp_d;
        int         w;
        int         win;
        int         exp_w;
        apply_reset();
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            pc[n] = 3'($urandom_range(0, 7));
            pa[n] = 8'($urandom);
            pb[n] = 8'($urandom);
            set_req(n, 1'b1, pc[n], pa[n], pb[n]);
        end
        exp_w = 0;
        #1;
        for (int k = 0; k < 256; k++) begin
            w = 0;
            while (!(bus.req0_ready || bus.req1_ready) && w < 4) begin
                cyc();
                w++;
            end
            n_checks++;
            if (w == 4) begin
                n_fail++;
                $display("FAIL b2b_timeout: op %0d no grant within 4 cycles", k);
                break;
            end
            win = bus.req1_ready ? 1 : 0;
            n_checks++;
            if (win != exp_w || (bus.req0_ready && bus.req1_ready)) begin
                n_fail++;
                $display("FAIL b2b_grant: op %0d ready0=%b ready1=%b required winner %0d",
                         k, bus.req0_ready, bus.req1_ready, exp_w);
            end
            exp_d = alu_model(pc[win], pa[win], pb[win]);
            cyc();
            pc[win] = 3'($urandom_range(0, 7));
            pa[win] = 8'($urandom);
            pb[win] = 8'($urandom);
            set_req(win, 1'b1, pc[win], pa[win], pb[win]);
            cyc();
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_id !== exp_w[0]) begin
                n_fail++;
                $display("FAIL b2b_rsp: op %0d valid=%b data=%h id=%b required 1 %h %0d",
                         k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, exp_d, exp_w);
            end
            $display("b2b op %0d: req%0d -> %h", k, win, bus.rsp_data);
            cyc();
            exp_cnt++;
            exp_w = 1 - exp_w;
        end
        n_checks++;
        if (bus.op_cnt !== 8'h00 || exp_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_wrap: op_cnt=%h required 00", bus.op_cnt);
        end
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        bus.rsp_ready = 1'b0;
        cyc();
        // the last accepted cycle may have granted one more op; flush it
        apply_reset();
    endtask

    task automatic test_random();
        bit         pend[2];
        logic [2:0] pc[2];
        logic [7:0] pa[2];
        logic [7:0] pb[2];
        logic [7:0] exp_d;
        int         exp_w;
        int         hold;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
                    pend[n] = 1'b1;
                    pc[n] = 3'($urandom_range(0, 7));
                    pa[n] = 8'($urandom);
                    pb[n] = 8'($urandom);
                    set_req(n, 1'b1, pc[n], pa[n], pb[n]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1;
                pc[0] = 3'd7;
                pa[0] = 8'($urandom);
                pb[0] = 8'($urandom);
                set_req(0, 1'b1, pc[0], pa[0], pb[0]);
            end
            if (pend[0] && pend[1]) exp_w = last_win ? 0 : 1;
            else                    exp_w = pend[1] ? 1 : 0;
            #1;
            n_checks++;
            if (bus.req0_ready !== (exp_w == 0) || bus.req1_ready !== (exp_w == 1)) begin
                n_fail++;
                $display("FAIL rnd_grant: op %0d ready0=%b ready1=%b required winner %0d",
                         k, bus.req0_ready, bus.req1_ready, exp_w);
            end
            exp_d = alu_model(pc[exp_w], pa[exp_w], pb[exp_w]);
            last_win = exp_w[0];
            cyc();
            pend[exp_w] = 1'b0;
            set_req(exp_w, 1'b0, 3'd0, 8'h00, 8'h00);
            cyc();
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_id !== exp_w[0] ||
                    bus.rsp_zero !== (exp_d == 8'h00) || bus.rsp_pari !== ($countones(exp_d) % 2 == 1) ||
                    bus.op_cnt !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL rnd_rsp: op %0d valid=%b data=%h id=%b zero=%b pari=%b cnt=%h required 1 %h %0d cnt %h",
                             k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_zero, bus.rsp_pari,
                             bus.op_cnt, exp_d, exp_w, exp_cnt);
                end
                if (h < hold) cyc();
            end
            $display("rnd op %0d: req%0d cmd=%0d %h,%h -> %h", k, exp_w, pc[exp_w], pa[exp_w], pb[exp_w], bus.rsp_data);
            bus.rsp_ready = 1'b1;
            cyc();
            bus.rsp_ready = 1'b0;
            exp_cnt++;
            n_checks++;
            if (bus.op_cnt !== exp_cnt || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_done: op %0d op_cnt=%h valid=%b required %h 0", k, bus.op_cnt, bus.rsp_valid, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
